// File: rtl/mov_arbiter.sv
// mov_arbiter: arbitrates NREQ requesters onto one shared MOV destination register, one move per 4 cycles.
// Build option: define MOV_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module mov_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] src_bus,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      mov_src,
    output logic                  mov_enable,
    output logic                  busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]  mov_src_q, mov_src_d;
    logic              mov_enable_q, mov_enable_d;
    logic              busy_q, busy_d;
    logic [IDX_W-1:0]  win;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NREQ-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (v[k]) idx = IDX_W'(k);
        end
        return idx;
    endfunction

    // Requests above the last owner win first; otherwise wrap to the lowest asserted index.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                 input logic [IDX_W-1:0] ptr);
        logic [NREQ-1:0] upper;
        upper = '0;
        for (int k = 0; k < NREQ; k++) begin
            upper[k] = r[k] && (k > int'(ptr));
        end
        return (upper != '0) ? lowest_set(upper) : lowest_set(r);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] w);
        logic [NREQ-1:0] v;
        v = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (int'(w) == k) v[k] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] pick_src(input logic [NREQ*WIDTH-1:0] bus,
                                                  input logic [IDX_W-1:0]      w);
        logic [WIDTH-1:0] s;
        s = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (int'(w) == k) s = bus[k*WIDTH +: WIDTH];
        end
        return s;
    endfunction

    always_comb begin
`ifdef MOV_ARB_FIXED_PRIO_EN
        win = lowest_set(req);
`else
        win = rr_pick(req, ptr_q);
`endif
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        grant_d      = grant_q;
        ack_d        = '0;
        mov_src_d    = mov_src_q;
        mov_enable_d = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    owner_d   = win;
                    grant_d   = onehot(win);
                    mov_src_d = pick_src(src_bus, win);
                    busy_d    = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                mov_enable_d = 1'b1;
                state_d      = ISSUE;
            end
            // The MOV unit captures mov_src on the edge that enters ACK.
            ISSUE: begin
                ack_d   = grant_q;
                state_d = ACK;
            end
            ACK: begin
                grant_d = '0;
                busy_d  = 1'b0;
`ifndef MOV_ARB_FIXED_PRIO_EN
                ptr_d   = owner_q;
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ptr_q        <= IDX_W'(NREQ - 1);
            owner_q      <= '0;
            grant_q      <= '0;
            ack_q        <= '0;
            mov_src_q    <= '0;
            mov_enable_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            grant_q      <= grant_d;
            ack_q        <= ack_d;
            mov_src_q    <= mov_src_d;
            mov_enable_q <= mov_enable_d;
            busy_q       <= busy_d;
        end
    end

    assign grant      = grant_q;
    assign ack        = ack_q;
    assign mov_src    = mov_src_q;
    assign mov_enable = mov_enable_q;
    assign busy       = busy_q;

    // Structural invariants of the move sequence.
    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant_q));
    a_en_one_cycle:  assert property (@(posedge clk) disable iff (!rst) mov_enable_q |=> !mov_enable_q);
    a_ack_one_cycle: assert property (@(posedge clk) disable iff (!rst) (ack_q != '0) |=> (ack_q == '0));
    a_en_in_move:    assert property (@(posedge clk) disable iff (!rst) mov_enable_q |-> busy_q);

endmodule

// File: tb/tb_mov_arbiter.sv
// Self-checking bench for mov_arbiter: vector table, scoreboard on ack, and multi-cycle corner sequences.
module tb_mov_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] src_bus = '0;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      mov_src;
    logic                  mov_enable;
    logic                  busy;
    logic [WIDTH-1:0]      dest = '0;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [NREQ-1:0]       r;
        logic [NREQ*WIDTH-1:0] s;
        logic [NREQ-1:0]       g;
        logic [WIDTH-1:0]      d;
    } vec_t;

    typedef struct {
        logic [NREQ-1:0]  g;
        logic [WIDTH-1:0] d;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];

    mov_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .src_bus    (src_bus),
        .grant      (grant),
        .ack        (ack),
        .mov_src    (mov_src),
        .mov_enable (mov_enable),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Model of the shared MOV destination register (not reset).
    always @(posedge clk) if (mov_enable) dest <= mov_src;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every ack must match the oldest outstanding move.
    always @(negedge clk) begin
        exp_t e;
        if (rst && ack != '0) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL ack_unexpected: ack=%b with no pending move, expected none", ack);
            end else begin
                e = sb.pop_front();
                check("ack_owner", 64'(ack), 64'(e.g));
                check("mov_dest", 64'(dest), 64'(e.d));
            end
        end
    end

    task automatic push_exp(input logic [NREQ-1:0] g, input logic [WIDTH-1:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic wait_grant(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (grant != '0) begin
                cycles = i;
                break;
            end
        end
        if (cycles == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL grant_timeout: grant=%b, expected nonzero within 12 cycles", grant);
        end
    endtask

    // Called on a negedge with the arbiter idle; leaves it idle on a negedge.
    task automatic move(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] s,
                        input logic [NREQ-1:0] eg, input logic [WIDTH-1:0] ed);
        int cyc;
        req     = r;
        src_bus = s;
        push_exp(eg, ed);
        wait_grant(cyc);
        if (cyc == 0) return;
        check("grant", 64'(grant), 64'(eg));
        check("busy_on", 64'(busy), 64'd1);
        check("mov_src", 64'(mov_src), 64'(ed));
        check("mov_enable_pre", 64'(mov_enable), 64'd0);
        @(negedge clk);
        check("mov_enable_on", 64'(mov_enable), 64'd1);
        check("ack_early", 64'(ack), 64'd0);
        @(negedge clk);
        check("mov_enable_off", 64'(mov_enable), 64'd0);
        req = '0;
        @(negedge clk);
        check("idle_after_ack", 64'({busy, grant, ack}), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cyc;
        bit  seen;
        logic [NREQ-1:0] order [5];

        vecs[0] = '{4'b0100, {16'h3003, 16'h000A, 16'h1001, 16'h0000}, 4'b0100, 16'h000A};
        vecs[1] = '{4'b0011, {16'h3013, 16'h2012, 16'h1011, 16'h0010}, 4'b0001, 16'h0010};
`ifdef MOV_ARB_FIXED_PRIO_EN
        vecs[2] = '{4'b0011, {16'h3023, 16'h2022, 16'h1021, 16'h0020}, 4'b0001, 16'h0020};
        vecs[3] = '{4'b1001, {16'h3033, 16'h2032, 16'h1031, 16'h0030}, 4'b0001, 16'h0030};
        order   = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        vecs[2] = '{4'b0011, {16'h3023, 16'h2022, 16'h1021, 16'h0020}, 4'b0010, 16'h1021};
        vecs[3] = '{4'b1001, {16'h3033, 16'h2032, 16'h1031, 16'h0030}, 4'b1000, 16'h3033};
        order   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        vecs[4] = '{4'b1001, {16'h3043, 16'h2042, 16'h1041, 16'h0040}, 4'b0001, 16'h0040};
        vecs[5] = '{4'b1000, {16'hFFFF, 16'h2052, 16'h1051, 16'h0050}, 4'b1000, 16'hFFFF};

        // Reset state
        #5;
        check("rst_outputs", 64'({grant, ack, mov_enable, busy}), 64'd0);
        check("rst_mov_src", 64'(mov_src), 64'd0);
        #5 rst = 1'b1;
        @(negedge clk);
        check("idle_outputs", 64'({grant, ack, mov_enable, busy}), 64'd0);

        for (int i = 0; i < 6; i++) begin
            move(vecs[i].r, vecs[i].s, vecs[i].g, vecs[i].d);
        end

        // Late source change after the grant must not reach the MOV unit
        req     = 4'b0010;
        src_bus = {16'h0000, 16'h0000, 16'hF00C, 16'h0000};
        push_exp(4'b0010, 16'hF00C);
        wait_grant(cyc);
        check("late_grant", 64'(grant), 64'h2);
        src_bus[1*WIDTH +: WIDTH] = 16'h1234;
        @(negedge clk);
        check("late_mov_src", 64'(mov_src), 64'hF00C);
        @(negedge clk);
        req = '0;
        @(negedge clk);

        // Request dropped mid-move still completes, with no re-grant
        req     = 4'b1000;
        src_bus = {16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        push_exp(4'b1000, 16'hFFFF);
        wait_grant(cyc);
        check("drop_grant", 64'(grant), 64'h8);
        @(negedge clk);
        req = '0;
        check("drop_enable", 64'(mov_enable), 64'd1);
        @(negedge clk);
        @(negedge clk);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (grant != '0) seen = 1'b1;
        end
        check("drop_no_regrant", 64'(seen), 64'd0);

        // Idle hold: no writes to the MOV register
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mov_enable) seen = 1'b1;
        end
        check("idle_no_enable", 64'(seen), 64'd0);
        check("idle_dest_kept", 64'(dest), 64'hFFFF);

        // Reset between the enable edge and the capture edge discards the move
        req     = 4'b0010;
        src_bus = {16'h0000, 16'h0000, 16'h5555, 16'h0000};
        wait_grant(cyc);
        check("rstmid_grant", 64'(grant), 64'h2);
        @(negedge clk);
        check("rstmid_enable", 64'(mov_enable), 64'd1);
        rst = 1'b0;
        #1;
        check("rstmid_clear", 64'({grant, ack, mov_enable, busy}), 64'd0);
        check("rstmid_mov_src", 64'(mov_src), 64'd0);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        check("rstmid_dest", 64'(dest), 64'hFFFF);
        rst = 1'b1;
        @(negedge clk);

        // Fairness with all requests held: grants every 4 cycles
        req     = '1;
        src_bus = {16'hC3C3, 16'hC2C2, 16'hC1C1, 16'hC0C0};
        for (int k = 0; k < 5; k++) begin
            push_exp(order[k], (order[k] == 4'b0001) ? 16'hC0C0 :
                               (order[k] == 4'b0010) ? 16'hC1C1 :
                               (order[k] == 4'b0100) ? 16'hC2C2 : 16'hC3C3);
            wait_grant(cyc);
            check("fair_grant", 64'(grant), 64'(order[k]));
            if (k > 0) check("fair_period", 64'(cyc), 64'd1);
            @(negedge clk);
            @(negedge clk);
            if (k == 4) req = '0;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
